// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem reads,
// and presents each instruction with its PC until decode accepts it.
module fetch_stage #(
  parameter int                   ADDR_W    = 16,
  parameter int                   INSTR_W   = 16,
  parameter int                   PC_STEP   = 4,
  parameter logic [ADDR_W-1:0]    RESET_PC  = 16'h0000,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  pc_plus4_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               if_valid
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   opc_q, opc_d;
  logic [ADDR_W-1:0]   opc4_q, opc4_d;

  logic                xfer;
  logic                buf_free;
  logic                load;
  logic [INSTR_W-1:0]  load_instr;
  logic [ADDR_W-1:0]   load_pc;

  assign xfer     = valid_q & ~stall;
  assign buf_free = ~valid_q | xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_ISSUE;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      opc_q        <= '0;
      opc4_q       <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
      opc4_q       <= opc4_d;
    end
  end

  // Next state, PC and skid capture
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load         = 1'b0;
    load_instr   = imem_rdata;
    load_pc      = pc_q;
    unique case (state_q)
      S_ISSUE: begin
        if (redirect_en) pc_d = redirect_pc;
        else state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? S_ISSUE : S_DROP;
        end else if (imem_rvalid) begin
          pc_d = pc_q + STEP;
          if (buf_free) begin
            load    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_en) begin
          pc_d    = redirect_pc;
          state_d = S_ISSUE;
        end else if (!stall) begin
          load       = 1'b1;
          load_instr = skid_instr_q;
          load_pc    = skid_pc_q;
          state_d    = S_ISSUE;
        end
      end
      S_DROP: begin
        if (redirect_en) pc_d = redirect_pc;
        if (imem_rvalid) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // Output buffer: flush beats load beats drain
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    opc4_d  = opc4_q;
    if (redirect_en) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      opc_d   = load_pc;
      opc4_d  = load_pc + STEP;
    end else if (xfer) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  always_comb begin
    imem_req  = ~reset & (state_q == S_ISSUE) & ~redirect_en;
    imem_addr = reset ? RESET_PC : pc_q;
  end

  assign pc_out          = opc_q;
  assign pc_plus4_out    = opc4_q;
  assign instruction_out = instr_q;
  assign if_valid        = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-driven memory responses,
// stalls, redirects, wrap-around and mid-operation reset.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] pc_out;
  logic [15:0] pc_plus4_out;
  logic [15:0] instruction_out;
  logic        if_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .pc_plus4_out    (pc_plus4_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic v,
                      input logic [15:0] pc, input logic [15:0] pc4,
                      input logic [15:0] ins);
    check({tag, ".valid"}, 32'(if_valid), 32'(v));
    check({tag, ".pc"}, 32'(pc_out), 32'(pc));
    check({tag, ".pc4"}, 32'(pc_plus4_out), 32'(pc4));
    check({tag, ".instr"}, 32'(instruction_out), 32'(ins));
  endtask

  task automatic req(input string tag, input logic r,
                     input logic [15:0] a);
    #1;
    check({tag, ".req"}, 32'(imem_req), 32'(r));
    if (r) check({tag, ".addr"}, 32'(imem_addr), 32'(a));
  endtask

  initial begin
    reset = 1; stall = 0; redirect_en = 0; redirect_pc = '0;
    imem_rvalid = 0; imem_rdata = '0;
    tick(); tick();
    req("rst", 1'b0, 16'h0);
    check("rst.addr", 32'(imem_addr), 32'h0);
    outs("rst", 1'b0, 16'h0, 16'h0, 16'h0);

    // free run with 1-cycle memory
    reset = 0;
    req("run0", 1'b1, 16'h0000);
    tick();
    imem_rvalid = 1; imem_rdata = 16'h1234;
    req("run0w", 1'b0, 16'h0);
    tick();
    imem_rvalid = 0;
    outs("run0o", 1'b1, 16'h0000, 16'h0004, 16'h1234);
    req("run1", 1'b1, 16'h0004);
    tick();
    outs("run1d", 1'b0, 16'h0000, 16'h0004, 16'h0000);
    imem_rvalid = 1; imem_rdata = 16'h5678;
    tick();
    imem_rvalid = 0;
    outs("run1o", 1'b1, 16'h0004, 16'h0008, 16'h5678);
    req("run2", 1'b1, 16'h0008);

    // stall while waiting -> HOLD
    stall = 1;
    tick();
    outs("stw", 1'b1, 16'h0004, 16'h0008, 16'h5678);
    imem_rvalid = 1; imem_rdata = 16'h9ABC;
    tick();
    imem_rvalid = 0;
    req("hold0", 1'b0, 16'h0);
    outs("hold0", 1'b1, 16'h0004, 16'h0008, 16'h5678);
    tick();
    req("hold1", 1'b0, 16'h0);
    outs("hold1", 1'b1, 16'h0004, 16'h0008, 16'h5678);
    stall = 0;
    tick();
    outs("skid", 1'b1, 16'h0008, 16'h000C, 16'h9ABC);
    req("skidr", 1'b1, 16'h000C);

    // redirect while waiting, late response dropped
    tick();
    outs("rdw", 1'b0, 16'h0008, 16'h000C, 16'h0000);
    redirect_en = 1; redirect_pc = 16'h0010;
    req("rdw", 1'b0, 16'h0);
    tick();
    redirect_en = 0;
    tick();
    req("drop", 1'b0, 16'h0);
    imem_rvalid = 1; imem_rdata = 16'hDEAD;
    tick();
    imem_rvalid = 0;
    outs("drop", 1'b0, 16'h0008, 16'h000C, 16'h0000);
    req("rd10", 1'b1, 16'h0010);

    // redirect coincident with response
    tick();
    redirect_en = 1; redirect_pc = 16'h0020;
    imem_rvalid = 1; imem_rdata = 16'h1111;
    tick();
    redirect_en = 0; imem_rvalid = 0;
    check("coin.valid", 32'(if_valid), 32'h0);
    req("coin", 1'b1, 16'h0020);

    // wrap-around at top of address space
    redirect_en = 1; redirect_pc = 16'hFFFC;
    req("wrapr", 1'b0, 16'h0);
    tick();
    redirect_en = 0;
    req("wrap0", 1'b1, 16'hFFFC);
    tick();
    imem_rvalid = 1; imem_rdata = 16'hBEEF;
    tick();
    imem_rvalid = 0;
    outs("wrap", 1'b1, 16'hFFFC, 16'h0000, 16'hBEEF);
    req("wrapn", 1'b1, 16'h0000);

    // reset while in HOLD
    stall = 1;
    tick();
    imem_rvalid = 1; imem_rdata = 16'h4321;
    tick();
    imem_rvalid = 0;
    req("hold2", 1'b0, 16'h0);
    check("hold2.valid", 32'(if_valid), 32'h1);
    reset = 1;
    tick();
    outs("rst2", 1'b0, 16'h0, 16'h0, 16'h0);
    req("rst2", 1'b0, 16'h0);
    check("rst2.addr", 32'(imem_addr), 32'h0);
    reset = 0; stall = 0;
    req("rst2r", 1'b1, 16'h0000);
    imem_rvalid = 1; imem_rdata = 16'h7777;
    tick();
    check("late.valid", 32'(if_valid), 32'h0);
    imem_rdata = 16'hAAAA;
    tick();
    imem_rvalid = 0;
    outs("rst2o", 1'b1, 16'h0000, 16'h0004, 16'hAAAA);
    req("rst2n", 1'b1, 16'h0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
